// File: rtl/ram_burst_ctrl.sv
// Burst front end for a small synchronous RAM: streams write beats in, or issues
// consecutive read addresses and returns the data on a valid-qualified port.
module ram_burst_ctrl #(
    parameter int AW     = 4,
    parameter int DW     = 2,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    // Address arithmetic is modulo 2**AW, so the top location wraps to zero.
    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] addr);
        return addr + ADDR_ONE;
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     cur_addr_q;
    logic [AW-1:0]     cur_addr_d;
    logic [AW-1:0]     remaining_q;
    logic [AW-1:0]     remaining_d;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [RD_LAT-1:0] rd_pipe_d;
    logic              cmd_ready_q;
    logic              cmd_ready_d;
    logic              wr_ready_q;
    logic              wr_ready_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              ram_oe_q;
    logic              ram_oe_d;
    logic              issue_s;

    // Next-state, address/beat counters and read-valid pipe.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        issue_s     = (state_q == READ);
        rd_pipe_d   = {RD_LAT{1'b0}};
        rd_pipe_d[0] = issue_s;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_wr ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    cur_addr_d = addr_next(cur_addr_q);
                    if (remaining_q == ADDR_ZERO) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = remaining_q - ADDR_ONE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            READ: begin
                cur_addr_d = addr_next(cur_addr_q);
                if (remaining_q == ADDR_ZERO) begin
                    state_d = DRAIN;
                end else begin
                    remaining_d = remaining_q - ADDR_ONE;
                end
            end
            DRAIN: begin
                // Leave once the beat now leaving the pipe is its last occupant.
                if (rd_pipe_d == {RD_LAT{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded outputs, computed one cycle ahead so they leave from flops.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        ram_oe_d    = (state_d == READ) || (state_d == DRAIN);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= ADDR_ZERO;
            remaining_q <= ADDR_ZERO;
            rd_pipe_q   <= {RD_LAT{1'b0}};
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_pipe_q   <= rd_pipe_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_oe_q    <= ram_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = cur_addr_q;
    // Write pins follow wr_valid directly so a beat lands in the cycle it is offered.
    assign ram_we    = wr_ready_q & wr_valid;
    assign ram_din   = wr_ready_q ? wr_data : {DW{1'b0}};
    assign rd_valid  = rd_pipe_q[RD_LAT-1];
    assign rd_data   = rd_pipe_q[RD_LAT-1] ? ram_dout : {DW{1'b0}};

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: table of bursts against a behavioural RAM, with
// scoreboards for RAM writes and returned read data.
module tb_ram_burst_ctrl;
    localparam int AW     = 4;
    localparam int DW     = 2;
    localparam int RD_LAT = 1;
    localparam int NVEC   = 11;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        logic [31:0]   data;
        int            gap;
        int            poke;
        int            exp_busy;
        int            exp_first;
    } vec_t;

    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;

    logic [DW-1:0]    shadow [16];
    logic [DW-1:0]    exp_rd [$];
    logic [AW+DW-1:0] exp_wr [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural 16x2 RAM with RD_LAT cycles of read latency.
    logic [DW-1:0] mem   [16];
    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rpipe[0] <= ram_oe ? mem[ram_addr] : 2'b00;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    function automatic logic [DW-1:0] beat(input logic [31:0] d, input int i);
        return d[2*i +: 2];
    endfunction

    initial begin : monitor
        logic [AW+DW-1:0] ew;
        logic [DW-1:0]    er;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (ram_we) begin
                if (exp_wr.size() == 0) begin
                    report_unexpected("unexpected_write", {ram_addr, ram_din});
                end else begin
                    ew = exp_wr.pop_front();
                    check("write_addr_data", {ram_addr, ram_din}, ew);
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                if (exp_rd.size() == 0) begin
                    report_unexpected("unexpected_read_beat", rd_data);
                end else begin
                    er = exp_rd.pop_front();
                    check("read_data", rd_data, er);
                end
            end
            if (cmd_ready || done) check("ram_pins_quiet", {ram_we, ram_oe}, 32'd0);
        end
    end

    task automatic run_burst(input vec_t v);
        int            cyc;
        int            acc;
        int            nbeat;
        int            first;
        int            gap_left;
        int            d0;
        bit            just_acc;
        logic [AW-1:0] a;

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        a = v.addr;
        for (int i = 0; i <= int'(v.len); i++) begin
            if (v.wr) begin
                shadow[a] = beat(v.data, i);
                exp_wr.push_back({a, beat(v.data, i)});
            end else begin
                exp_rd.push_back(shadow[a]);
            end
            a = a + 4'd1;
        end
        if (v.wr) begin
            wr_valid = 1'b1;
            wr_data  = beat(v.data, 0);
        end
        d0 = done_cnt;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1; acc = 0; nbeat = 0; first = -1; gap_left = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            just_acc = wr_ready && wr_valid;
            if (just_acc) acc++;
            if (ram_we || rd_valid) begin
                nbeat++;
                if (first < 0) first = cyc;
            end
            if (v.wr && !wr_valid) check("no_write_while_stalled", ram_we, 32'd0);
            if (cyc >= 200) begin
                report_unexpected("burst_timeout", cyc);
                break;
            end
            @(posedge clk); #1;
            cyc++;
            cmd_valid = (cyc == v.poke);
            cmd_wr    = ~v.wr;
            if (v.wr) begin
                if (acc > int'(v.len)) begin
                    wr_valid = 1'b0;
                end else if (just_acc && v.gap > 0) begin
                    wr_valid = 1'b0;
                    gap_left = v.gap;
                end else if (gap_left > 0) begin
                    gap_left--;
                    if (gap_left == 0) begin
                        wr_valid = 1'b1;
                        wr_data  = beat(v.data, acc);
                    end
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = beat(v.data, acc);
                end
            end
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        check("busy_cycles", cyc - 1, v.exp_busy);
        check("beat_count", nbeat, int'(v.len) + 1);
        check("first_beat_cycle", first, v.exp_first);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("reads_outstanding", exp_rd.size(), 32'd0);
        check("writes_outstanding", exp_wr.size(), 32'd0);
    endtask

    initial begin : stim
        logic [AW-1:0] a;
        int            rv0;
        int            d0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 2'b00;

        //            wr    addr   len    data            gap poke busy first
        tbl[0]  = '{1'b1, 4'd0,  4'd15, 32'hE4E4_1B1B, 0, 0, 17, 1};
        tbl[1]  = '{1'b1, 4'd3,  4'd1,  32'h0000_0006, 0, 0, 3,  1};
        tbl[2]  = '{1'b0, 4'd3,  4'd1,  32'h0000_0000, 0, 0, 4,  1 + RD_LAT};
        tbl[3]  = '{1'b1, 4'd15, 4'd2,  32'h0000_0039, 0, 0, 4,  1};
        tbl[4]  = '{1'b0, 4'd15, 4'd2,  32'h0000_0000, 0, 0, 5,  1 + RD_LAT};
        tbl[5]  = '{1'b1, 4'd5,  4'd2,  32'h0000_0023, 3, 0, 10, 1};
        tbl[6]  = '{1'b0, 4'd7,  4'd15, 32'h0000_0000, 0, 0, 18, 1 + RD_LAT};
        tbl[7]  = '{1'b0, 4'd0,  4'd3,  32'h0000_0000, 0, 2, 6,  1 + RD_LAT};
        tbl[8]  = '{1'b0, 4'd9,  4'd0,  32'h0000_0000, 0, 0, 3,  1 + RD_LAT};
        tbl[9]  = '{1'b1, 4'd9,  4'd0,  32'h0000_0001, 0, 0, 2,  1};
        tbl[10] = '{1'b0, 4'd8,  4'd2,  32'h0000_0000, 0, 0, 5,  1 + RD_LAT};

        #1 rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom);
            cmd_wr    = 1'($urandom);
            cmd_addr  = 4'($urandom);
            cmd_len   = 4'($urandom);
            wr_valid  = 1'($urandom);
            wr_data   = 2'($urandom);
            @(negedge clk);
            check("reset_outputs",
                  {ram_we, ram_oe, ram_addr, ram_din, rd_valid, rd_data, done, busy, wr_ready},
                  32'd0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 32'd1);

        for (int k = 0; k < NVEC; k++) run_burst(tbl[k]);

        // Long read abandoned by reset after five addresses have been issued.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd15;
        a = 4'd0;
        for (int i = 0; i < 16; i++) begin
            exp_rd.push_back(shadow[a]);
            a = a + 4'd1;
        end
        rv0 = rv_cnt;
        d0  = done_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("oe_before_reset", ram_oe, 32'd1);
        rst = 1'b0;
        #2;
        check("reset_kills_read", {rd_valid, rd_data, ram_oe, ram_we, busy, done}, 32'd0);
        check("beats_before_reset", rv_cnt - rv0, 5 - RD_LAT);
        exp_rd.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_mid_reset", cmd_ready, 32'd1);
        check("no_done_after_abandon", done_cnt - d0, 32'd0);
        run_burst(tbl[2]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Request-side front end for the 16x2 synchronous RAM. It accepts one burst command at a time over a valid/ready handshake.
- It streams write beats into the RAM, or reads consecutive locations out, and drives the RAM's we/oe/addr/din pins directly.
- Read data is returned on a valid-qualified port. Addresses auto-increment and wrap at the top of memory.

Parameters:
- AW, 4, RAM address width; depth = 2**AW.
- DW, 2, RAM data width.
- RD_LAT, 1, cycles from a read address on ram_addr (with ram_oe=1) to valid data on ram_dout; legal range 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  burst start address.
- cmd_len  in  AW  beats minus 1 (0 = 1 beat, 15 = 16 beats).
- wr_valid  in  1  write beat present.
- wr_data  in  DW  write beat data.
- wr_ready  out  1  write beat accepted this cycle.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  DW  read beat data.
- busy  out  1  burst in progress (not IDLE).
- done  out  1  one-cycle pulse when a burst completes.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data.

Behaviour:
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Reset (rst=0, asynchronous): state=IDLE; address and beat counters=0; read-latency pipe cleared.
  - ram_we=0, ram_oe=0, ram_addr=0, ram_din=0, rd_valid=0, rd_data=0, done=0, busy=0, wr_ready=0.
  - cmd_ready=1 once rst is released.
- cmd_ready = (state==IDLE). A command transfers on cmd_valid & cmd_ready.
  - On transfer, cur_addr<=cmd_addr and remaining<=cmd_len are captured.
  - Next state is WRITE if cmd_wr=1, else READ.
  - cmd_valid in any other state is ignored and not queued.
- WRITE:
  - wr_ready=1 for the whole state.
  - ram_we = wr_valid; ram_addr=cur_addr; ram_din=wr_data; all combinational from the registered state/address.
  - Each accepted beat: cur_addr<=cur_addr+1 modulo 2**AW (15 wraps to 0).
  - If remaining==0 on an accepted beat -> DONE, else remaining<=remaining-1.
  - wr_valid=0 stalls the burst with no RAM write; there is no timeout.
- READ:
  - ram_oe=1; one address is issued per cycle, with the same increment and wrap rule.
  - Each issued beat enters an RD_LAT-deep valid shift pipe.
  - Last beat issued -> DRAIN.
- DRAIN: ram_oe stays 1 until the pipe is empty, then -> DONE.
- Read return: rd_valid = pipe output; rd_data = ram_dout in that cycle.
  - There is no backpressure; the consumer must accept every beat.
  - Exactly cmd_len+1 rd_valid pulses per read burst, in address order.
- DONE: done=1 for exactly one cycle, then -> IDLE. cmd_ready=0 during DONE.
- busy=1 in WRITE, READ, DRAIN, DONE.
- ram_we=0 and ram_oe=0 in IDLE and DONE.
- A read burst of 16 beats from any start address covers every location exactly once.
- Mid-burst reset: the burst is abandoned immediately and all outputs take their reset values. No done pulse, no further rd_valid. Writes already performed stay in the RAM.
- Latency:
  - Write: first ram_we in the cycle after the command transfer, if wr_valid=1.
  - Read: first rd_valid 1+RD_LAT cycles after the command transfer.
  - A read burst of N beats occupies N+RD_LAT+1 cycles from transfer until cmd_ready returns.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0; cmd_ready=1 on the first cycle after release.
- Write burst: cmd_wr=1, addr=3, len=1, beats 2'b10 then 2'b01 with wr_valid held high -> ram_we high two cycles, (addr,din)=(3,10) then (4,01); done one cycle later; cmd_ready back.
- Read-back: cmd_wr=0, addr=3, len=1 against the RAM model -> rd_valid on two consecutive cycles with rd_data 10 then 01, first one RD_LAT+1 cycles after transfer; single done pulse.
- Wrap: write addr=15, len=2, data 01,10,11 -> ram_addr sequence 15,0,1; readback addr=15, len=2 returns 01,10,11.
- Stall and ignore:
  - Write len=2 with wr_valid low for 3 cycles between beats -> no ram_we during the gap; exactly 3 writes.
  - cmd_valid pulsed while busy -> ignored; no extra burst.
- Reset mid-burst: read addr=0, len=15, rst=0 after 5 beats issued -> rd_valid and ram_oe drop at once; no done pulse; a fresh command after release executes normally.
